// File: rtl/wb_merge.sv
// rtl/wb_merge.sv - writeback merge of two in-order lanes and a queued long-latency stream; optional WB_TRACE_EN debug outputs
module wb_merge #(
    parameter int LQ_DEPTH = 2,
    parameter int LQ_PTR_W = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem1_valid,
    input  logic                mem1_we,
    input  logic [4:0]          mem1_waddr,
    input  logic [31:0]         mem1_wdata,
    input  logic                mem2_valid,
    input  logic                mem2_we,
    input  logic [4:0]          mem2_waddr,
    input  logic [31:0]         mem2_wdata,
    input  logic                long_valid,
    input  logic [4:0]          long_waddr,
    input  logic [31:0]         long_wdata,
    output logic                long_ready,
    output logic                we_1,
    output logic [4:0]          waddr_1,
    output logic [31:0]         wdata_1,
    output logic                we_2,
    output logic [4:0]          waddr_2,
    output logic [31:0]         wdata_2,
    output logic [LQ_PTR_W:0]   lq_count
`ifdef WB_TRACE_EN
    ,
    output logic [31:0]         debug_wb_cnt,
    output logic [1:0]          debug_wb_rf_wen,
    output logic                debug_lq_ovf_seen
`endif
);

    logic [4:0]          r_lq_addr [LQ_DEPTH];
    logic [31:0]         r_lq_data [LQ_DEPTH];
    logic [LQ_PTR_W-1:0] r_head;
    logic [LQ_PTR_W-1:0] r_tail;
    logic [LQ_PTR_W:0]   r_count;
    logic                r_long_ready;

    logic                w_req1, w_req2, w_hs, w_in_live, w_bypass, w_enq;
    logic                w_p1_long, w_idx2;
    logic [1:0]          w_nfree, w_nq, w_deq;
    logic                w_p1_we, w_p2_we;
    logic [4:0]          w_p1_addr, w_p2_addr;
    logic [31:0]         w_p1_data, w_p2_data;
    logic [LQ_PTR_W:0]   w_count_next;
    logic [LQ_PTR_W-1:0] w_head1, w_head_idx2;

    assign long_ready = r_long_ready;
    assign lq_count   = r_count;
    assign w_head1    = r_head + LQ_PTR_W'(1);
    assign w_head_idx2 = r_head + LQ_PTR_W'(w_idx2);

    // Lane requests, WAW squash, long candidate selection and queue bookkeeping
    always_comb begin
        w_req2    = mem2_valid & mem2_we & (mem2_waddr != 5'd0);
        w_req1    = mem1_valid & mem1_we & (mem1_waddr != 5'd0)
                    & ~(w_req2 & (mem1_waddr == mem2_waddr));
        w_hs      = long_valid & r_long_ready;
        w_in_live = w_hs & (long_waddr != 5'd0);
        w_nfree   = {1'b0, ~w_req1} + {1'b0, ~w_req2};
        w_nq      = (r_count >= (LQ_PTR_W+1)'(2)) ? 2'd2 : r_count[1:0];
        w_deq     = (w_nq < w_nfree) ? w_nq : w_nfree;
        // The incoming word may only skip the queue once every queued entry leaves now
        w_bypass  = w_in_live & ((LQ_PTR_W+1)'(w_nfree) > r_count);
        w_enq     = w_in_live & ~w_bypass;
        w_p1_long = ~w_req1 & ((w_nq != 2'd0) | w_bypass);
        w_idx2    = w_p1_long;

        w_p1_we   = 1'b0;
        w_p1_addr = waddr_1;
        w_p1_data = wdata_1;
        if (w_req1) begin
            w_p1_we   = 1'b1;
            w_p1_addr = mem1_waddr;
            w_p1_data = mem1_wdata;
        end else if (w_nq != 2'd0) begin
            w_p1_we   = 1'b1;
            w_p1_addr = r_lq_addr[r_head];
            w_p1_data = r_lq_data[r_head];
        end else if (w_bypass) begin
            w_p1_we   = 1'b1;
            w_p1_addr = long_waddr;
            w_p1_data = long_wdata;
        end

        w_p2_we   = 1'b0;
        w_p2_addr = waddr_2;
        w_p2_data = wdata_2;
        if (w_req2) begin
            w_p2_we   = 1'b1;
            w_p2_addr = mem2_waddr;
            w_p2_data = mem2_wdata;
        end else if ({1'b0, w_idx2} < w_nq) begin
            w_p2_we   = 1'b1;
            w_p2_addr = r_lq_addr[w_head_idx2];
            w_p2_data = r_lq_data[w_head_idx2];
        end else if (w_bypass && ({1'b0, w_idx2} == w_nq)) begin
            w_p2_we   = 1'b1;
            w_p2_addr = long_waddr;
            w_p2_data = long_wdata;
        end

        w_count_next = r_count + (LQ_PTR_W+1)'(w_enq) - (LQ_PTR_W+1)'(w_deq);
    end

    // Queue storage, pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                r_lq_addr[i] <= 5'd0;
                r_lq_data[i] <= 32'd0;
            end
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_long_ready <= 1'b1;
        end else begin
            if (w_enq) begin
                r_lq_addr[r_tail] <= long_waddr;
                r_lq_data[r_tail] <= long_wdata;
            end
            r_tail       <= r_tail + LQ_PTR_W'(w_enq);
            r_head       <= r_head + LQ_PTR_W'(w_deq);
            r_count      <= w_count_next;
            r_long_ready <= (w_count_next < (LQ_PTR_W+1)'(LQ_DEPTH));
        end
    end

    // Registered write ports; address/data hold while a port is idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_1    <= 1'b0;
            waddr_1 <= 5'd0;
            wdata_1 <= 32'd0;
            we_2    <= 1'b0;
            waddr_2 <= 5'd0;
            wdata_2 <= 32'd0;
        end else begin
            we_1    <= w_p1_we;
            waddr_1 <= w_p1_addr;
            wdata_1 <= w_p1_data;
            we_2    <= w_p2_we;
            waddr_2 <= w_p2_addr;
            wdata_2 <= w_p2_data;
        end
    end

`ifdef WB_TRACE_EN
    logic [3:0]  r_stall_cnt;
    logic [31:0] r_wb_cnt;
    logic        r_ovf_seen;

    assign debug_wb_cnt      = r_wb_cnt;
    assign debug_wb_rf_wen   = {we_2, we_1};
    assign debug_lq_ovf_seen = r_ovf_seen;

    // Write counter and sticky detector for a long producer stalled 16+ cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_cnt    <= 32'd0;
            r_stall_cnt <= 4'd0;
            r_ovf_seen  <= 1'b0;
        end else begin
            r_wb_cnt <= r_wb_cnt + 32'(we_1) + 32'(we_2);
            if (long_valid && !r_long_ready) begin
                if (r_stall_cnt == 4'd15) begin
                    r_ovf_seen <= 1'b1;
                end else begin
                    r_stall_cnt <= r_stall_cnt + 4'd1;
                end
            end else begin
                r_stall_cnt <= 4'd0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_merge.sv
// tb/tb_wb_merge.sv - self-checking bench for wb_merge with a queue-based reference model
module tb_wb_merge;
    localparam int DEPTH = 2;

    logic        clk, rst;
    logic        mem1_valid, mem1_we, mem2_valid, mem2_we, long_valid;
    logic [4:0]  mem1_waddr, mem2_waddr, long_waddr;
    logic [31:0] mem1_wdata, mem2_wdata, long_wdata;
    logic        long_ready, we_1, we_2;
    logic [4:0]  waddr_1, waddr_2;
    logic [31:0] wdata_1, wdata_2;
    logic [1:0]  lq_count;
`ifdef WB_TRACE_EN
    logic [31:0] debug_wb_cnt;
    logic [1:0]  debug_wb_rf_wen;
    logic        debug_lq_ovf_seen;
`endif

    wb_merge #(.LQ_DEPTH(DEPTH), .LQ_PTR_W(1)) dut (
        .clk(clk), .rst(rst),
        .mem1_valid(mem1_valid), .mem1_we(mem1_we), .mem1_waddr(mem1_waddr), .mem1_wdata(mem1_wdata),
        .mem2_valid(mem2_valid), .mem2_we(mem2_we), .mem2_waddr(mem2_waddr), .mem2_wdata(mem2_wdata),
        .long_valid(long_valid), .long_waddr(long_waddr), .long_wdata(long_wdata), .long_ready(long_ready),
        .we_1(we_1), .waddr_1(waddr_1), .wdata_1(wdata_1),
        .we_2(we_2), .waddr_2(waddr_2), .wdata_2(wdata_2),
        .lq_count(lq_count)
`ifdef WB_TRACE_EN
        , .debug_wb_cnt(debug_wb_cnt), .debug_wb_rf_wen(debug_wb_rf_wen), .debug_lq_ovf_seen(debug_lq_ovf_seen)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t        mq[$];
    bit          m_ready;
    logic        exp_we1, exp_we2;
    logic [4:0]  exp_a1, exp_a2;
    logic [31:0] exp_d1, exp_d2;
    int          n_checks, n_fail;

    task automatic model_reset();
        mq.delete();
        m_ready = 1'b1;
        exp_we1 = 0; exp_a1 = 0; exp_d1 = 0;
        exp_we2 = 0; exp_a2 = 0; exp_d2 = 0;
    endtask

    // Drive one cycle of inputs, advance the reference model, land 1ns after the edge
    task automatic tick(input logic v1, input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic v2, input logic w2, input logic [4:0] a2, input logic [31:0] d2,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
        bit r1, r2, inc, inc_used;
        ent_t e;
        mem1_valid = v1; mem1_we = w1; mem1_waddr = a1; mem1_wdata = d1;
        mem2_valid = v2; mem2_we = w2; mem2_waddr = a2; mem2_wdata = d2;
        long_valid = lv; long_waddr = la; long_wdata = ld;
        r2 = v2 && w2 && a2 != 0;
        r1 = v1 && w1 && a1 != 0 && !(r2 && a1 == a2);
        inc = lv && m_ready && la != 0;
        inc_used = 0;
        if (r1) begin exp_we1 = 1; exp_a1 = a1; exp_d1 = d1; end
        else if (mq.size() > 0) begin e = mq.pop_front(); exp_we1 = 1; exp_a1 = e.a; exp_d1 = e.d; end
        else if (inc) begin inc_used = 1; exp_we1 = 1; exp_a1 = la; exp_d1 = ld; end
        else exp_we1 = 0;
        if (r2) begin exp_we2 = 1; exp_a2 = a2; exp_d2 = d2; end
        else if (mq.size() > 0) begin e = mq.pop_front(); exp_we2 = 1; exp_a2 = e.a; exp_d2 = e.d; end
        else if (inc && !inc_used) begin inc_used = 1; exp_we2 = 1; exp_a2 = la; exp_d2 = ld; end
        else exp_we2 = 0;
        if (inc && !inc_used) begin e.a = la; e.d = ld; mq.push_back(e); end
        m_ready = (mq.size() < DEPTH);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(0,0,0,0, 0,0,0,0, 0,0,0);
    endtask

    task automatic test_reset();
        n_checks++; if ({we_1, we_2} !== 2'b00) begin n_fail++; $display("FAIL reset_we got=%b want=00", {we_1, we_2}); end
        n_checks++; if ({waddr_1, waddr_2, wdata_1, wdata_2} !== 74'd0) begin n_fail++; $display("FAIL reset_addr_data a1=%0d a2=%0d d1=%h d2=%h want 0", waddr_1, waddr_2, wdata_1, wdata_2); end
        n_checks++; if (lq_count !== 2'd0 || long_ready !== 1'b1) begin n_fail++; $display("FAIL reset_queue cnt=%0d ready=%b want 0/1", lq_count, long_ready); end
    endtask

    task automatic test_two_lanes();
        tick(1,1,5'd3,32'h11, 1,1,5'd4,32'h22, 0,0,0);
        n_checks++; if ({we_1, waddr_1, wdata_1} !== {1'b1, 5'd3, 32'h11}) begin n_fail++; $display("FAIL lanes_p1 got we=%b a=%0d d=%h want 1/3/11", we_1, waddr_1, wdata_1); end
        n_checks++; if ({we_2, waddr_2, wdata_2} !== {1'b1, 5'd4, 32'h22}) begin n_fail++; $display("FAIL lanes_p2 got we=%b a=%0d d=%h want 1/4/22", we_2, waddr_2, wdata_2); end
    endtask

    task automatic test_waw();
        tick(1,1,5'd7,32'hA, 1,1,5'd7,32'hB, 0,0,0);
        n_checks++; if (we_1 !== 1'b0) begin n_fail++; $display("FAIL waw_p1 we=%b want 0", we_1); end
        n_checks++; if ({we_2, waddr_2, wdata_2} !== {1'b1, 5'd7, 32'hB}) begin n_fail++; $display("FAIL waw_p2 got we=%b a=%0d d=%h want 1/7/b", we_2, waddr_2, wdata_2); end
    endtask

    task automatic test_bypass();
        tick(0,0,0,0, 0,0,0,0, 1,5'd9,32'hDEAD);
        n_checks++; if ({we_1, waddr_1, wdata_1} !== {1'b1, 5'd9, 32'hDEAD}) begin n_fail++; $display("FAIL bypass_p1 got we=%b a=%0d d=%h want 1/9/dead", we_1, waddr_1, wdata_1); end
        n_checks++; if (lq_count !== 2'd0 || we_2 !== 1'b0) begin n_fail++; $display("FAIL bypass_cnt cnt=%0d we2=%b want 0/0", lq_count, we_2); end
    endtask

    task automatic test_queue_full();
        tick(1,1,5'd1,32'h100, 1,1,5'd2,32'h200, 1,5'd5,32'h1);
        tick(1,1,5'd1,32'h101, 1,1,5'd2,32'h201, 1,5'd6,32'h2);
        n_checks++; if (lq_count !== 2'd2 || long_ready !== 1'b0) begin n_fail++; $display("FAIL full_state cnt=%0d ready=%b want 2/0", lq_count, long_ready); end
        tick(1,1,5'd1,32'h102, 1,1,5'd2,32'h202, 1,5'd8,32'h3);
        n_checks++; if (lq_count !== 2'd2 || waddr_1 !== 5'd1 || waddr_2 !== 5'd2) begin n_fail++; $display("FAIL full_stall cnt=%0d a1=%0d a2=%0d want 2/1/2", lq_count, waddr_1, waddr_2); end
        tick(0,0,0,0, 0,0,0,0, 1,5'd8,32'h3);
        n_checks++; if ({we_1, waddr_1, wdata_1, we_2, waddr_2, wdata_2} !== {1'b1, 5'd5, 32'h1, 1'b1, 5'd6, 32'h2}) begin n_fail++; $display("FAIL drain_pair p1=%b/%0d/%h p2=%b/%0d/%h want 1/5/1 1/6/2", we_1, waddr_1, wdata_1, we_2, waddr_2, wdata_2); end
        n_checks++; if (lq_count !== 2'd0 || long_ready !== 1'b1) begin n_fail++; $display("FAIL drain_state cnt=%0d ready=%b want 0/1", lq_count, long_ready); end
        tick(0,0,0,0, 0,0,0,0, 1,5'd8,32'h3);
        n_checks++; if ({we_1, waddr_1, wdata_1} !== {1'b1, 5'd8, 32'h3}) begin n_fail++; $display("FAIL stalled_accept got we=%b a=%0d d=%h want 1/8/3", we_1, waddr_1, wdata_1); end
    endtask

    task automatic test_r0_lane();
        tick(1,1,5'd1,32'h1, 1,1,5'd2,32'h2, 1,5'd12,32'h5);
        n_checks++; if (lq_count !== 2'd1) begin n_fail++; $display("FAIL r0_setup cnt=%0d want 1", lq_count); end
        tick(1,1,5'd0,32'h77, 1,1,5'd13,32'h9, 0,0,0);
        n_checks++; if ({we_1, waddr_1, wdata_1} !== {1'b1, 5'd12, 32'h5}) begin n_fail++; $display("FAIL r0_p1 got we=%b a=%0d d=%h want 1/12/5", we_1, waddr_1, wdata_1); end
        n_checks++; if ({we_2, waddr_2, lq_count} !== {1'b1, 5'd13, 2'd0}) begin n_fail++; $display("FAIL r0_p2 got we=%b a=%0d cnt=%0d want 1/13/0", we_2, waddr_2, lq_count); end
    endtask

    task automatic test_async_reset();
        tick(1,1,5'd1,32'h1, 1,1,5'd2,32'h2, 1,5'd20,32'hAA);
        tick(1,1,5'd1,32'h1, 1,1,5'd2,32'h2, 1,5'd21,32'hBB);
        long_valid = 0; mem1_valid = 0; mem2_valid = 0;
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({we_1, we_2, waddr_1} !== {2'b00, 5'd0}) begin n_fail++; $display("FAIL async_we we=%b%b a1=%0d want 00/0", we_1, we_2, waddr_1); end
        n_checks++; if (lq_count !== 2'd0 || long_ready !== 1'b1) begin n_fail++; $display("FAIL async_queue cnt=%0d ready=%b want 0/1", lq_count, long_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            n_checks++; if ({we_1, we_2} !== 2'b00) begin n_fail++; $display("FAIL async_ghost cyc=%0d we=%b%b want 00", i, we_1, we_2); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0,3) != 0, $urandom_range(0,3) != 0, 5'($urandom_range(0,7)), $urandom,
                 $urandom_range(0,3) != 0, $urandom_range(0,3) != 0, 5'($urandom_range(0,7)), $urandom,
                 $urandom_range(0,4) < 3, 5'($urandom_range(0,15)), $urandom);
            n_checks++; if ({we_1, waddr_1, wdata_1} !== {exp_we1, exp_a1, exp_d1}) begin n_fail++; $display("FAIL rand_p1 cyc=%0d got %b/%0d/%h want %b/%0d/%h", i, we_1, waddr_1, wdata_1, exp_we1, exp_a1, exp_d1); end
            n_checks++; if ({we_2, waddr_2, wdata_2} !== {exp_we2, exp_a2, exp_d2}) begin n_fail++; $display("FAIL rand_p2 cyc=%0d got %b/%0d/%h want %b/%0d/%h", i, we_2, waddr_2, wdata_2, exp_we2, exp_a2, exp_d2); end
            n_checks++; if (lq_count !== 2'(mq.size()) || long_ready !== m_ready) begin n_fail++; $display("FAIL rand_queue cyc=%0d cnt=%0d ready=%b want %0d/%b", i, lq_count, long_ready, mq.size(), m_ready); end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b0;
        mem1_valid = 0; mem1_we = 0; mem1_waddr = 0; mem1_wdata = 0;
        mem2_valid = 0; mem2_we = 0; mem2_waddr = 0; mem2_wdata = 0;
        long_valid = 0; long_waddr = 0; long_wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        test_two_lanes();
        test_waw();
        test_bypass();
        test_queue_full();
        test_r0_lane();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
